// File: rtl/conv_window_controller.sv
// Raster-order pixel sequencer for a KxK convolver: one shift strobe per accepted
// pixel and a registered window-valid flag with the output-map coordinate.
module conv_window_controller #(
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int COL_W       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  parameter int ROW_W       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  shift_en,
  output logic [DATA_WIDTH-1:0] shift_data,
  output logic                  window_valid,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             accept;
  logic             last_pixel;
  logic             win_hit;

  // Handshake: a pixel transfers on any cycle with in_valid && in_ready; the
  // source must hold in_data stable while in_valid is high and in_ready is low.
  assign accept     = in_valid & in_ready;
  assign shift_en   = accept;
  assign shift_data = in_data;
  assign last_pixel = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));
  assign win_hit    = accept && (row >= ROW_W'(KERNEL_SIZE - 1)) &&
                      (col >= COL_W'(KERNEL_SIZE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_pixel) state_n = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters park on the last pixel once the frame completes; start re-arms them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept && !last_pixel) begin
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Registered so the flag lines up with the shift registers updated on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window_valid <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
    end else begin
      window_valid <= win_hit;
      if (win_hit) begin
        out_row <= row - ROW_W'(KERNEL_SIZE - 1);
        out_col <= col - COL_W'(KERNEL_SIZE - 1);
      end
    end
  end

endmodule
